// File: rtl/am_demod_if.sv
`default_nettype none
// ============================================================================
//  Module      : am_demod_if
//  Description : Sample-in / envelope-out bundle for the coherent AM
//                demodulator.
//                master : sample source and envelope consumer
//                slave  : am_demod
//  Signals     : in_valid   sample strobe (source -> demod)
//                sin_s      modulated sample, offset binary
//                sin_c      reference carrier sample, offset binary
//                env_out    decimated envelope, unsigned
//                env_valid  one-cycle strobe on env_out update
//                env_peak   per-frame envelope maximum (peak build only)
//                peak_valid one-cycle strobe on env_peak update
//  Revision    : 1.0  initial release
// ============================================================================
interface am_demod_if;
  logic       in_valid;
  logic [7:0] sin_s;
  logic [7:0] sin_c;
  logic [7:0] env_out;
  logic       env_valid;
  logic [7:0] env_peak;
  logic       peak_valid;

  modport master (
    output in_valid, sin_s, sin_c,
    input  env_out, env_valid, env_peak, peak_valid
  );

  modport slave (
    input  in_valid, sin_s, sin_c,
    output env_out, env_valid, env_peak, peak_valid
  );
endinterface
`default_nettype wire

// File: rtl/am_demod.sv
`default_nettype none
// ============================================================================
//  Module      : am_demod
//  Description : Coherent AM demodulator. Multiplies the modulated sample by
//                the reference carrier, integrates 2^LOG2_N products, dumps
//                the scaled and saturated average as an 8-bit envelope.
//                Optional per-frame peak tracking when AM_DEMOD_PEAK_EN is
//                defined; otherwise env_peak / peak_valid are tied to 0.
//  Ports       : clk      system clock, rising edge
//                rst      asynchronous active-high reset
//                dmd_io   am_demod_if.slave (samples in, envelope out)
//  Parameters  : LOG2_N     log2 of samples per output (1..10)
//                OUT_SHIFT  arithmetic right shift of the 16-bit average
//                LOG2_FRAME log2 of outputs per peak frame
//  Revision    : 1.0  initial release
// ============================================================================
module am_demod #(
  parameter int LOG2_N     = 5,
  parameter int OUT_SHIFT  = 6,
  parameter int LOG2_FRAME = 4
) (
  input  logic       clk,
  input  logic       rst,
  am_demod_if.slave  dmd_io
);

  localparam int              c_ACC_W    = 16 + LOG2_N;
  localparam logic [LOG2_N-1:0] c_CNT_LAST = '1;

  if (LOG2_N < 1 || LOG2_N > 10 || LOG2_FRAME < 1) begin : g_param_check
    $error("am_demod: LOG2_N must be 1..10 and LOG2_FRAME >= 1");
  end

  // Stage 1: offset binary -> two's complement (flip the MSB)
  logic signed [7:0]         s1_q, c1_q;
  logic                      v1_q, v2_q;
  // Stage 2: product, range -16256..16384 fits 16 bits signed
  logic signed [15:0]        prod_q;
  // Stage 3: integrate and dump
  logic signed [c_ACC_W-1:0] acc_q, acc_d;
  logic [LOG2_N-1:0]         cnt_q, cnt_d;
  logic [7:0]                env_q, env_d;
  logic                      env_valid_q, env_valid_d;

  logic signed [c_ACC_W-1:0] sum;
  logic signed [15:0]        avg;
  logic signed [15:0]        sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= '0;
      c1_q   <= '0;
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      prod_q <= '0;
    end else begin
      if (dmd_io.in_valid) begin
        s1_q <= {~dmd_io.sin_s[7], dmd_io.sin_s[6:0]};
        c1_q <= {~dmd_io.sin_c[7], dmd_io.sin_c[6:0]};
      end
      v1_q   <= dmd_io.in_valid;
      v2_q   <= v1_q;
      prod_q <= s1_q * c1_q;
    end
  end

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    env_d       = env_q;
    env_valid_d = 1'b0;
    sum         = acc_q + prod_q;
    // Average of the frame, then output scaling; both arithmetic shifts
    avg         = 16'(sum >>> LOG2_N);
    sh          = avg >>> OUT_SHIFT;
    if (v2_q) begin
      if (cnt_q == c_CNT_LAST) begin
        acc_d       = '0;
        cnt_d       = '0;
        env_valid_d = 1'b1;
        if (sh[15])
          env_d = 8'd0;
        else if (|sh[14:8])
          env_d = 8'd255;
        else
          env_d = sh[7:0];
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      env_q       <= '0;
      env_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      env_q       <= env_d;
      env_valid_q <= env_valid_d;
    end
  end

  assign dmd_io.env_out   = env_q;
  assign dmd_io.env_valid = env_valid_q;

`ifdef AM_DEMOD_PEAK_EN
  localparam logic [LOG2_FRAME-1:0] c_FRAME_LAST = '1;

  logic [LOG2_FRAME-1:0] frame_cnt_q;
  logic [7:0]            run_max_q;
  logic [7:0]            peak_q;
  logic                  peak_valid_q;
  logic [7:0]            new_max;

  // Running max including the envelope value just presented
  assign new_max = (env_q > run_max_q) ? env_q : run_max_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q  <= '0;
      run_max_q    <= '0;
      peak_q       <= '0;
      peak_valid_q <= 1'b0;
    end else begin
      peak_valid_q <= 1'b0;
      if (env_valid_q) begin
        if (frame_cnt_q == c_FRAME_LAST) begin
          frame_cnt_q  <= '0;
          run_max_q    <= '0;
          peak_q       <= new_max;
          peak_valid_q <= 1'b1;
        end else begin
          frame_cnt_q <= frame_cnt_q + 1'b1;
          run_max_q   <= new_max;
        end
      end
    end
  end

  assign dmd_io.env_peak   = peak_q;
  assign dmd_io.peak_valid = peak_valid_q;
`else
  assign dmd_io.env_peak   = 8'd0;
  assign dmd_io.peak_valid = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_am_demod.sv
`default_nettype none
// ============================================================================
//  Module      : tb_am_demod
//  Description : Scoreboard bench for am_demod (LOG2_N=5, OUT_SHIFT=6,
//                LOG2_FRAME=2). The driver pushes expected envelope / peak
//                values with their due clock edge; a negedge monitor pops
//                and compares whenever the DUT strobes an output.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_am_demod;

  typedef struct {
    int val;
    int edge_n;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   edge_n = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  exp_t env_sb[$];
  exp_t peak_sb[$];

  // Reference model state
  int m_acc = 0;
  int m_cnt = 0;
  int m_fcnt = 0;
  int m_max = 0;

  am_demod_if bus_if ();

  am_demod #(
    .LOG2_N    (5),
    .OUT_SHIFT (6),
    .LOG2_FRAME(2)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .dmd_io(bus_if.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string name, input int act, input int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, expv, edge_n);
    end
  endtask

  function automatic void model_reset();
    m_acc  = 0;
    m_cnt  = 0;
    m_fcnt = 0;
    m_max  = 0;
  endfunction

  // One valid sample captured at edge e
  function automatic void model_sample(input int s, input int c, input int e);
    int sh;
    int v;
    exp_t x;
    m_acc += (s - 128) * (c - 128);
    m_cnt++;
    if (m_cnt == 32) begin
      sh = (m_acc >>> 5) >>> 6;
      v  = (sh < 0) ? 0 : (sh > 255) ? 255 : sh;
      x.val = v;
      x.edge_n = e + 2;
      env_sb.push_back(x);
      m_acc = 0;
      m_cnt = 0;
      if (v > m_max) m_max = v;
      m_fcnt++;
      if (m_fcnt == 4) begin
        x.val = m_max;
        x.edge_n = e + 3;
        peak_sb.push_back(x);
        m_fcnt = 0;
        m_max  = 0;
      end
    end
  endfunction

  task automatic drive(input int s, input int c, input bit v);
    @(negedge clk);
    bus_if.in_valid = v;
    bus_if.sin_s    = 8'(s);
    bus_if.sin_c    = 8'(c);
    if (v) model_sample(s, c, edge_n + 1);
  endtask

  task automatic run(input int s, input int c, input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      drive(s, c, 1'b1);
      if (gap) drive(s, c, 1'b0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(128, 128, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    chk("rst_env_out", int'(bus_if.env_out), 0);
    rst = 1'b0;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t x;
    if (!rst) begin
      if (bus_if.env_valid) begin
        if (env_sb.size() == 0) begin
          chk("env_unexpected", 1, 0);
        end else begin
          x = env_sb.pop_front();
          chk("env_out", int'(bus_if.env_out), x.val);
          chk("env_edge", edge_n, x.edge_n);
        end
      end
      if (bus_if.peak_valid) begin
        if (peak_sb.size() == 0) begin
          chk("peak_unexpected", 1, 0);
        end else begin
          x = peak_sb.pop_front();
          chk("env_peak", int'(bus_if.env_peak), x.val);
          chk("peak_edge", edge_n, x.edge_n);
        end
      end
    end
  end

  initial begin
    bus_if.in_valid = 1'b0;
    bus_if.sin_s    = 8'd128;
    bus_if.sin_c    = 8'd128;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_env_out", int'(bus_if.env_out), 0);
    chk("reset_env_valid", int'(bus_if.env_valid), 0);
    chk("reset_env_peak", int'(bus_if.env_peak), 0);
    chk("reset_peak_valid", int'(bus_if.peak_valid), 0);

    // Full-scale: 127*127 = 16129 -> avg 16129 -> >>6 = 252
    run(255, 255, 64, 1'b0);
    idle(4);
    chk("full_scale_hold", int'(bus_if.env_out), 252);

    // Zero signal -> 0; negative product -16256 -> clamped to 0
    run(128, 255, 32, 1'b0);
    idle(4);
    chk("zero_signal", int'(bus_if.env_out), 0);
    run(255, 255, 32, 1'b0);
    run(0, 255, 32, 1'b0);
    idle(4);
    chk("neg_clamp", int'(bus_if.env_out), 0);

    // -128*-128 = 16384 -> sh 256 -> saturate 255
    run(0, 0, 32, 1'b0);
    idle(4);
    chk("saturate", int'(bus_if.env_out), 255);

    // Half-full frame: 16*16129/32 = 8064 -> 126
    run(255, 255, 16, 1'b0);
    run(128, 255, 16, 1'b0);
    idle(4);
    chk("half_frame", int'(bus_if.env_out), 126);

    // Bubbles every other clock: still 32 valid samples per output
    run(255, 255, 64, 1'b1);
    idle(4);
    chk("gaps_hold", int'(bus_if.env_out), 252);

    // Reset mid-frame discards the partial sum
    run(255, 255, 20, 1'b0);
    idle(3);
    do_reset();
    run(255, 255, 31, 1'b0);
    idle(4);
    chk("post_reset_partial", int'(bus_if.env_out), 0);
    run(255, 255, 1, 1'b0);
    idle(4);
    chk("post_reset_full", int'(bus_if.env_out), 252);

    // Peak frames: outputs 100, 252, 50, 0 then four zeros
    do_reset();
    run(208, 208, 32, 1'b0);
    run(255, 255, 32, 1'b0);
    run(168, 208, 32, 1'b0);
    run(128, 255, 32, 1'b0);
    idle(4);
`ifdef AM_DEMOD_PEAK_EN
    chk("peak_frame1", int'(bus_if.env_peak), 252);
`else
    chk("peak_tied", int'(bus_if.env_peak), 0);
`endif
    run(128, 255, 128, 1'b0);
    idle(4);
    chk("peak_frame2", int'(bus_if.env_peak), 0);

    idle(6);
    chk("env_sb_drained", env_sb.size(), 0);
`ifdef AM_DEMOD_PEAK_EN
    chk("peak_sb_drained", peak_sb.size(), 0);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/am_demod.md
Name: am_demod

Overview:
- Coherent AM demodulator directly downstream of am_gen.
- Consumes the modulated sample (sin_s) and the reference carrier (sin_c), both 8-bit offset-binary.
- Forms the product s*c, then low-pass filters it by integrate-and-dump over 2^LOG2_N samples.
- Emits a decimated 8-bit unsigned envelope with a one-cycle valid strobe, for display or DAC.

Parameters:
- LOG2_N, 5: log2 of samples integrated per output (N = 32); legal range 1..10.
- OUT_SHIFT, 6: arithmetic right shift applied to the 16-bit average before saturation to 8 bits.
- LOG2_FRAME, 4: log2 of envelope outputs per peak frame; used only with AM_DEMOD_PEAK_EN.

Ports:
- clk, in, 1: system clock, rising edge.
- rst, in, 1: asynchronous, active-high reset.
- in_valid, in, 1: sample strobe; tie high when fed from am_gen every clock.
- sin_s, in, 8: modulated sample, offset binary (128 = zero).
- sin_c, in, 8: carrier sample, offset binary.
- env_out, out, 8: demodulated envelope, unsigned.
- env_valid, out, 1: one-cycle pulse when env_out updates.
- env_peak, out, 8: maximum env_out over the last frame (AM_DEMOD_PEAK_EN only).
- peak_valid, out, 1: one-cycle pulse when env_peak updates (AM_DEMOD_PEAK_EN only).

Behaviour:
- Reset (async assert, sync release):
  - All pipeline registers, accumulator and sample counter clear to 0.
  - env_out = 0, env_valid = 0, env_peak = 0, peak_valid = 0.
- Stage 1, at the edge where in_valid = 1:
  - s1 = {~sin_s[7], sin_s[6:0]} and c1 = {~sin_c[7], sin_c[6:0]} (signed 8-bit).
  - v1 <= in_valid.
- Stage 2: prod_q <= s1*c1, signed 16-bit; v2 <= v1. Range -16256..16384, no overflow.
- Stage 3: accumulator acc, signed, 16+LOG2_N bits; sample counter cnt, LOG2_N bits.
  - v2 = 1 and cnt != N-1: acc += prod_q; cnt++.
  - v2 = 1 and cnt == N-1 (dump):
    - sum = acc + prod_q.
    - avg = sum >>> LOG2_N, truncated to 16 bits.
    - sh = avg >>> OUT_SHIFT.
    - env_out <= 0 if sh < 0; 255 if sh > 255; else sh[7:0].
    - env_valid <= 1; acc <= 0; cnt <= 0.
  - v2 = 0: acc and cnt hold.
  - env_valid is 0 on every cycle except the dump cycle.
- Latency: if the Nth valid sample is captured at edge E, env_out and env_valid update at edge E+2.
- Throughput: one sample per clock, one output per N valid samples.
- Gaps: in_valid low does not advance cnt. A frame spans exactly N valid samples regardless of gaps; bubbles propagate through v1/v2.
- env_out holds its value between dumps.
- Reset mid-frame: the partial sum is discarded; the next output needs N fresh valid samples after reset release.
- Simultaneous dump and new input: no conflict; the pipeline keeps accepting samples, and the sample following the dump starts the new frame at cnt = 0.
- No backpressure; the consumer must take env_out on env_valid.

Optional Feature:
- Macro: AM_DEMOD_PEAK_EN.
- Defined:
  - A frame counter counts env_valid pulses; a running max register compares against each new env_out.
  - After 2^LOG2_FRAME outputs: env_peak <= max(running max, current env_out); peak_valid pulses 1 cycle, one edge after the final env_valid; running max clears to 0.
  - Reset clears the frame counter, running max, env_peak and peak_valid.
- Undefined: no peak logic is built; env_peak and peak_valid are tied to 0.

Test Plan:
- Constant sin_s = 255, sin_c = 255, in_valid = 1 -> env_out = 252 after 32 samples; env_valid pulses every 32 clocks; first pulse 2 edges after the 32nd capture.
- sin_s = 128, sin_c = 255 -> env_out = 0; sin_s = 0, sin_c = 255 (product -16256) -> env_out = 0 (negative clamp).
- sin_s = 0, sin_c = 0 (product 16384) -> avg 16384, sh 256 -> env_out = 255 (saturation).
- in_valid toggling 1/0 with constant 255/255 -> env_valid every 64 clocks; env_out = 252 unchanged.
- Assert rst after 20 samples, release, apply 32 samples of 255/255 -> single env_valid only after 32 post-reset samples; env_out = 0 until then.
- AM_DEMOD_PEAK_EN, LOG2_FRAME = 2: four outputs 100, 252, 50, 0 -> env_peak = 252 with peak_valid one edge after the 4th env_valid; next frame of all 0 -> env_peak = 0.
